// File: rtl/wb_regfile_if.sv
// W-stage to register-file bundle: write-back sources, commit controls,
// D-stage read ports and the exported write-back value / retired-write counter.
interface wb_regfile_if #(
   parameter int COUNT_W = 32
) ();
   logic [1:0]         WDSelW;
   logic               RFenW;
   logic [31:0]        FWW;
   logic [31:0]        DMRDW;
   logic [4:0]         A3W;
   logic [31:0]        PC8W;
   logic [31:0]        CP0OutW;
   logic [4:0]         A1;
   logic [4:0]         A2;
   logic [31:0]        RD1;
   logic [31:0]        RD2;
   logic [31:0]        WDW;
   logic [COUNT_W-1:0] WrCount;

   modport master (
      output WDSelW, RFenW, FWW, DMRDW, A3W, PC8W, CP0OutW, A1, A2,
      input  RD1, RD2, WDW, WrCount
   );

   modport slave (
      input  WDSelW, RFenW, FWW, DMRDW, A3W, PC8W, CP0OutW, A1, A2,
      output RD1, RD2, WDW, WrCount
   );
endinterface

// File: rtl/wb_regfile.sv
// MIPS write-back stage and 32x32 general register file with retired-write counter.
// Optional W->D read bypass is compiled in when GRF_BYPASS_EN is defined.
module wb_regfile #(
   parameter int COUNT_W = 32
) (
   input logic         clk,
   input logic         reset,
   wb_regfile_if.slave bus
);
   typedef logic [31:0] word_t;

   word_t              regs_r [0:31];
   logic [COUNT_W-1:0] wr_count_r;
   word_t              wd_s;
   word_t              rd1_s;
   word_t              rd2_s;
   logic               commit_s;

   function automatic word_t wb_select(
      input logic [1:0] sel,
      input word_t      fw,
      input word_t      dm,
      input word_t      pc8,
      input word_t      cp0
   );
      word_t res;
      case (sel)
         2'd0:    res = fw;
         2'd1:    res = dm;
         2'd2:    res = pc8;
         2'd3:    res = cp0;
         default: res = fw;
      endcase
      return res;
   endfunction

   // Write-back source mux and commit qualification ($0 writes never commit).
   always_comb begin
      wd_s     = wb_select(bus.WDSelW, bus.FWW, bus.DMRDW, bus.PC8W, bus.CP0OutW);
      commit_s = bus.RFenW && (bus.A3W != 5'd0);
   end

   // Register array and retired-write counter; reset wipes everything and blocks writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
         wr_count_r <= '0;
      end else if (commit_s) begin
         regs_r[bus.A3W] <= wd_s;
         wr_count_r      <= wr_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
         wr_count_r <= wr_count_r;
      end
   end

   // Read port 1; the bypass path is only reachable once reset is released.
   always_comb begin
      rd1_s = 32'h0000_0000;
      if (!reset) begin
         rd1_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
      end else if (commit_s && (bus.A1 == bus.A3W)) begin
         rd1_s = wd_s;
`endif
      end else if (bus.A1 == 5'd0) begin
         rd1_s = 32'h0000_0000;
      end else begin
         rd1_s = regs_r[bus.A1];
      end
   end

   // Read port 2, same structure as port 1.
   always_comb begin
      rd2_s = 32'h0000_0000;
      if (!reset) begin
         rd2_s = 32'h0000_0000;
`ifdef GRF_BYPASS_EN
      end else if (commit_s && (bus.A2 == bus.A3W)) begin
         rd2_s = wd_s;
`endif
      end else if (bus.A2 == 5'd0) begin
         rd2_s = 32'h0000_0000;
      end else begin
         rd2_s = regs_r[bus.A2];
      end
   end

   assign bus.RD1     = rd1_s;
   assign bus.RD2     = rd2_s;
   assign bus.WDW     = wd_s;
   assign bus.WrCount = wr_count_r;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a
// 4-bit counter exercises counter wrap.
module tb_wb_regfile;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;
   int   exp_count;

   wb_regfile_if #(.COUNT_W(32)) bus  ();
   wb_regfile_if #(.COUNT_W(4))  bus4 ();

   wb_regfile #(.COUNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
   wb_regfile #(.COUNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      bus.RFenW  = 1'b1;
      bus.A3W    = 5'd5;
      bus.WDSelW = 2'd0;
      bus.FWW    = 32'h1234;
      bus.A1     = 5'd5;
      bus.A2     = 5'd5;
      tick();
      n_cmp++; if (bus.RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got=%h exp=%h", bus.RD1, 32'h0); end
      n_cmp++; if (bus.RD2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2 got=%h exp=%h", bus.RD2, 32'h0); end
      n_cmp++; if (bus.WrCount !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.WrCount); end
      n_cmp++; if (bus.WDW !== 32'h1234) begin n_fail++; $display("FAIL reset_wdw got=%h exp=%h", bus.WDW, 32'h1234); end
      reset = 1'b1;
      tick();
      exp_count = 1;
      bus.RFenW = 1'b0;
      #1;
      n_cmp++; if (bus.RD1 !== 32'h1234) begin n_fail++; $display("FAIL release_write got=%h exp=%h", bus.RD1, 32'h1234); end
      n_cmp++; if (bus.WrCount !== 32'd1) begin n_fail++; $display("FAIL release_count got=%0d exp=1", bus.WrCount); end
   endtask

   task automatic test_select();
      logic [31:0] exp_val [4];
      exp_val[0] = 32'd1;
      exp_val[1] = 32'd2;
      exp_val[2] = 32'h3008;
      exp_val[3] = 32'd4;
      bus.FWW     = 32'd1;
      bus.DMRDW   = 32'd2;
      bus.PC8W    = 32'h3008;
      bus.CP0OutW = 32'd4;
      bus.A3W     = 5'd8;
      bus.A1      = 5'd8;
      bus.RFenW   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.WDSelW = i[1:0];
         #1;
         n_cmp++; if (bus.WDW !== exp_val[i]) begin n_fail++; $display("FAIL select_wdw%0d got=%h exp=%h", i, bus.WDW, exp_val[i]); end
         tick();
         exp_count++;
         n_cmp++; if (bus.RD1 !== exp_val[i]) begin n_fail++; $display("FAIL select_reg%0d got=%h exp=%h", i, bus.RD1, exp_val[i]); end
      end
      bus.RFenW = 1'b0;
      n_cmp++; if (bus.WrCount !== 32'(exp_count)) begin n_fail++; $display("FAIL select_count got=%0d exp=%0d", bus.WrCount, exp_count); end
   endtask

   task automatic test_zero_reg();
      bus.RFenW  = 1'b1;
      bus.A3W    = 5'd0;
      bus.WDSelW = 2'd0;
      bus.FWW    = 32'hFFFF_FFFF;
      bus.A1     = 5'd0;
      bus.A2     = 5'd0;
      #1;
      n_cmp++; if (bus.RD1 !== 32'h0) begin n_fail++; $display("FAIL zero_pre got=%h exp=%h", bus.RD1, 32'h0); end
      tick();
      n_cmp++; if (bus.RD2 !== 32'h0) begin n_fail++; $display("FAIL zero_post got=%h exp=%h", bus.RD2, 32'h0); end
      n_cmp++; if (bus.WrCount !== 32'(exp_count)) begin n_fail++; $display("FAIL zero_count got=%0d exp=%0d", bus.WrCount, exp_count); end
      bus.RFenW = 1'b0;
   endtask

   task automatic test_bypass();
      bus.RFenW  = 1'b1;
      bus.A3W    = 5'd9;
      bus.WDSelW = 2'd0;
      bus.FWW    = 32'd7;
      bus.A1     = 5'd9;
      bus.A2     = 5'd9;
      tick();
      exp_count++;
      bus.FWW = 32'hABCD;
      #1;
`ifdef GRF_BYPASS_EN
      n_cmp++; if (bus.RD1 !== 32'hABCD) begin n_fail++; $display("FAIL bypass_rd1 got=%h exp=%h", bus.RD1, 32'hABCD); end
      n_cmp++; if (bus.RD2 !== 32'hABCD) begin n_fail++; $display("FAIL bypass_rd2 got=%h exp=%h", bus.RD2, 32'hABCD); end
`else
      n_cmp++; if (bus.RD1 !== 32'd7) begin n_fail++; $display("FAIL old_rd1 got=%h exp=%h", bus.RD1, 32'd7); end
      n_cmp++; if (bus.RD2 !== 32'd7) begin n_fail++; $display("FAIL old_rd2 got=%h exp=%h", bus.RD2, 32'd7); end
`endif
      tick();
      exp_count++;
      bus.RFenW = 1'b0;
      #1;
      n_cmp++; if (bus.RD1 !== 32'hABCD) begin n_fail++; $display("FAIL after_rd1 got=%h exp=%h", bus.RD1, 32'hABCD); end
      n_cmp++; if (bus.RD2 !== 32'hABCD) begin n_fail++; $display("FAIL after_rd2 got=%h exp=%h", bus.RD2, 32'hABCD); end
   endtask

   task automatic test_disabled();
      bus.RFenW = 1'b0;
      bus.A3W   = 5'd9;
      bus.FWW   = 32'd55;
      bus.A1    = 5'd9;
      #1;
      n_cmp++; if (bus.RD1 !== 32'hABCD) begin n_fail++; $display("FAIL disabled_pre got=%h exp=%h", bus.RD1, 32'hABCD); end
      tick();
      n_cmp++; if (bus.RD1 !== 32'hABCD) begin n_fail++; $display("FAIL disabled_reg got=%h exp=%h", bus.RD1, 32'hABCD); end
      n_cmp++; if (bus.WrCount !== 32'(exp_count)) begin n_fail++; $display("FAIL disabled_count got=%0d exp=%0d", bus.WrCount, exp_count); end
   endtask

   task automatic test_back_to_back();
      bus.WDSelW = 2'd1;
      bus.RFenW  = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         bus.A3W   = r[4:0];
         bus.DMRDW = 32'hA000_0000 + 32'(r * 17);
         tick();
         exp_count++;
      end
      bus.RFenW = 1'b0;
      for (int r = 1; r <= 4; r += 2) begin
         bus.A1 = r[4:0];
         bus.A2 = 5'(r + 1);
         #1;
         n_cmp++; if (bus.RD1 !== 32'hA000_0000 + 32'(r * 17)) begin n_fail++; $display("FAIL b2b_rd1_r%0d got=%h exp=%h", r, bus.RD1, 32'hA000_0000 + 32'(r * 17)); end
         n_cmp++; if (bus.RD2 !== 32'hA000_0000 + 32'((r + 1) * 17)) begin n_fail++; $display("FAIL b2b_rd2_r%0d got=%h exp=%h", r + 1, bus.RD2, 32'hA000_0000 + 32'((r + 1) * 17)); end
      end
      n_cmp++; if (bus.WrCount !== 32'(exp_count)) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", bus.WrCount, exp_count); end
   endtask

   task automatic test_mid_reset();
      bus.RFenW  = 1'b1;
      bus.A3W    = 5'd10;
      bus.WDSelW = 2'd0;
      bus.FWW    = 32'h5555;
      bus.A1     = 5'd10;
      bus.A2     = 5'd9;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.RD2 !== 32'h0) begin n_fail++; $display("FAIL midrst_rd2 got=%h exp=%h", bus.RD2, 32'h0); end
      n_cmp++; if (bus.WrCount !== 32'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", bus.WrCount); end
      tick();
      bus.RFenW = 1'b0;
      reset     = 1'b1;
      exp_count = 0;
      #1;
      n_cmp++; if (bus.RD1 !== 32'h0) begin n_fail++; $display("FAIL midrst_lost got=%h exp=%h", bus.RD1, 32'h0); end
      n_cmp++; if (bus.RD2 !== 32'h0) begin n_fail++; $display("FAIL midrst_clr got=%h exp=%h", bus.RD2, 32'h0); end
   endtask

   task automatic test_wrap();
      bus4.RFenW  = 1'b1;
      bus4.A3W    = 5'd3;
      bus4.WDSelW = 2'd0;
      bus4.A1     = 5'd3;
      for (int k = 1; k <= 17; k++) begin
         bus4.FWW = 32'(k);
         tick();
         if (k == 15) begin
            n_cmp++; if (bus4.WrCount !== 4'd15) begin n_fail++; $display("FAIL wrap_15 got=%0d exp=15", bus4.WrCount); end
         end
         if (k == 16) begin
            n_cmp++; if (bus4.WrCount !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got=%0d exp=0", bus4.WrCount); end
         end
      end
      bus4.RFenW = 1'b0;
      #1;
      n_cmp++; if (bus4.WrCount !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got=%0d exp=1", bus4.WrCount); end
      n_cmp++; if (bus4.RD1 !== 32'd17) begin n_fail++; $display("FAIL wrap_reg got=%0d exp=17", bus4.RD1); end
   endtask

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      exp_count    = 0;
      reset        = 1'b0;
      bus.WDSelW   = 2'd0;
      bus.RFenW    = 1'b0;
      bus.FWW      = 32'h0;
      bus.DMRDW    = 32'h0;
      bus.A3W      = 5'd0;
      bus.PC8W     = 32'h0;
      bus.CP0OutW  = 32'h0;
      bus.A1       = 5'd0;
      bus.A2       = 5'd0;
      bus4.WDSelW  = 2'd0;
      bus4.RFenW   = 1'b0;
      bus4.FWW     = 32'h0;
      bus4.DMRDW   = 32'h0;
      bus4.A3W     = 5'd0;
      bus4.PC8W    = 32'h0;
      bus4.CP0OutW = 32'h0;
      bus4.A1      = 5'd0;
      bus4.A2      = 5'd0;
      #2;
      test_reset();
      test_select();
      test_zero_reg();
      test_bypass();
      test_disabled();
      test_back_to_back();
      test_mid_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general register file of the five-stage MIPS pipeline, consuming the outputs of the W pipeline register. Selects the write-back datum from the ALU/forwarded result, data-memory read data, PC+8 or CP0 read data. Commits it to a 32×32 register file. Serves the two D-stage read ports, and exports the write-back value and a retired-write counter for hazard forwarding and debug.

## Interface
Parameters:
- COUNT_W, 32, width of the retired-write counter

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when 0
- WDSelW  input  2  write-back source select from W register
- RFenW  input  1  register write enable from W register
- FWW  input  32  ALU/forwarded result
- DMRDW  input  32  data-memory read data, already extended
- A3W  input  5  destination register index
- PC8W  input  32  PC+8 of the W-stage instruction, for link writes
- CP0OutW  input  32  CP0 read data, for mfc0
- A1  input  5  D-stage read address, port 1
- A2  input  5  D-stage read address, port 2
- RD1  output  32  read data, port 1
- RD2  output  32  read data, port 2
- WDW  output  32  selected write-back value, to the forwarding muxes
- WrCount  output  COUNT_W  number of committed register writes since reset

## Operation
- Write-back select, combinational:
  - WDSelW=0 → FWW
  - WDSelW=1 → DMRDW
  - WDSelW=2 → PC8W
  - WDSelW=3 → CP0OutW
- WDW always equals the selected value, regardless of RFenW.
- A write commits when RFenW=1 and A3W≠0. On that rising edge, reg[A3W] takes WDW.
- Register 0 is hard-wired to 0:
  - Writes to it are discarded.
  - Reads of it return 0.
  - A write attempt to it does not count.
- Reads are combinational. RDn = 0 if An=0, otherwise reg[An], subject to the bypass described under Configuration.
- WrCount increments by 1 on every committed write and wraps modulo 2^COUNT_W (all-ones → 0).
- reset=0 asynchronously clears registers 1–31 and WrCount to 0.
  - While reset=0, writes are ignored.
  - RD1 and RD2 read 0 for every address. With the bypass compiled in, they still read 0: the bypass is gated off during reset.
  - WDW still reflects its inputs.
- A flushed W register (RFenW=0, A3W=0) produces no write and no count.

## Timing
- Write latency is 1 cycle: a value presented in cycle n is visible from reg[] after the rising edge ending cycle n.
- Without the bypass, a same-cycle read of A3W returns the old value.
- Read paths RD1, RD2 and WDW are purely combinational, with no registered outputs.
- Reset values: RD1=RD2=0, WrCount=0, WDW=mux(inputs).
- Reset release takes effect immediately. The first write can occur on the first rising edge with reset=1.
- If reset asserts mid-cycle, the pending write is lost and the register keeps value 0.

## Configuration
- GRF_BYPASS_EN defined: internal W→D bypass is enabled.
  - If reset=1, RFenW=1, A3W≠0 and An=A3W, then RDn returns WDW in the same cycle.
  - The D stage then needs no separate W-stage forwarding for source registers.
- GRF_BYPASS_EN undefined: RDn always returns the stored reg[An].
  - The pipeline must forward WDW externally.
- WrCount and the write path are identical in both builds.

## Test plan
- Reset: drive reset=0 with RFenW=1, A3W=5, FWW=32'h1234 and clock → RD1 at A1=5 is 0, WrCount=0. Release reset, clock once → reg[5]=32'h1234, WrCount=1.
- Source select: A3W=8, RFenW=1, then WDSelW=0..3 with FWW=1, DMRDW=2, PC8W=32'h3008, CP0OutW=4, one clock each → reg[8] reads 1, 2, 32'h3008, 4 in turn. WrCount rises by 4.
- $0 protection: RFenW=1, A3W=0, FWW=32'hFFFFFFFF and clock → RD1 at A1=0 is 0, WrCount unchanged.
- Bypass: A3W=A1=A2=9, RFenW=1, WDSelW=0, FWW=32'hABCD with reg[9]=7 before the edge.
  - With GRF_BYPASS_EN: RD1=RD2=32'hABCD before the edge.
  - Without GRF_BYPASS_EN: RD1=RD2=7 before the edge, 32'hABCD after.
- Disabled write: RFenW=0, A3W=9, FWW=55 and clock → reg[9] unchanged, WrCount unchanged.
- Counter wrap: build with COUNT_W=4 and perform 17 writes to register 3 → WrCount=1.
